// File: rtl/ds_issue_queue_if.sv
// ds_issue_queue_if: fetch-side push and execute-side issue handshake bundle.
// master = producer/consumer environment, slave = the issue queue.
interface ds_issue_queue_if #(
  parameter int XLEN = 32,
  parameter int PW   = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   in_payload;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic            in_use2;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_payload;
  logic [XLEN-1:0] out_src1;
  logic [XLEN-1:0] out_src2;

  modport master (
    output in_valid, in_payload, in_rs1,
    output in_rs2, in_use2, out_ready,
    input  in_ready, out_valid, out_payload,
    input  out_src1, out_src2
  );

  modport slave (
    input  in_valid, in_payload, in_rs1,
    input  in_rs2, in_use2, out_ready,
    output in_ready, out_valid, out_payload,
    output out_src1, out_src2
  );
endinterface

// File: rtl/ds_issue_queue.sv
// ds_issue_queue: in-order issue FIFO with operand forwarding and load-use hold.
// Define DS_PERF_CNT_EN to build the head-blocked stall counter.
module ds_issue_queue #(
  parameter int XLEN    = 32,
  parameter int PW      = 64,
  parameter int DEPTH   = 4,
  parameter int NUM_FWD = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  ds_issue_queue_if.slave         q,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD-1:0]      fwd_blk,
  input  logic [5*NUM_FWD-1:0]    fwd_waddr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata,
  output logic [15:0]             stall_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [PW-1:0]    r_pay [DEPTH];
  logic [4:0]       r_rs1 [DEPTH];
  logic [4:0]       r_rs2 [DEPTH];
  logic [DEPTH-1:0] r_use2;

  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_cnt;

  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_blocked;
  logic [4:0]      w_h_rs1;
  logic [4:0]      w_h_rs2;
  logic            w_h_use2;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic            w_b1;
  logic            w_b2;

  assign w_h_rs1  = r_rs1[r_rptr];
  assign w_h_rs2  = r_rs2[r_rptr];
  assign w_h_use2 = r_use2[r_rptr];
  assign w_empty  = (r_cnt == '0);

  assign rf_raddr1     = w_h_rs1;
  assign rf_raddr2     = w_h_rs2;
  assign q.out_payload = r_pay[r_rptr];
  assign q.out_src1    = w_src1;
  assign q.out_src2    = w_src2;

  // Walk channels oldest-to-youngest so the lowest index lands last.
  always_comb begin
    w_src1 = rf_rdata1;
    w_src2 = rf_rdata2;
    w_b1   = 1'b0;
    w_b2   = 1'b0;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if ((fwd_we[i] || fwd_blk[i]) &&
          fwd_waddr[5*i +: 5] != 5'd0 &&
          fwd_waddr[5*i +: 5] == w_h_rs1) begin
        w_b1 = fwd_blk[i];
      end
      if ((fwd_we[i] || fwd_blk[i]) &&
          fwd_waddr[5*i +: 5] != 5'd0 &&
          fwd_waddr[5*i +: 5] == w_h_rs2 &&
          w_h_use2) begin
        w_b2 = fwd_blk[i];
      end
      if (fwd_we[i] &&
          fwd_waddr[5*i +: 5] != 5'd0 &&
          fwd_waddr[5*i +: 5] == w_h_rs1) begin
        w_src1 = fwd_wdata[XLEN*i +: XLEN];
      end
      if (fwd_we[i] &&
          fwd_waddr[5*i +: 5] != 5'd0 &&
          fwd_waddr[5*i +: 5] == w_h_rs2 &&
          w_h_use2) begin
        w_src2 = fwd_wdata[XLEN*i +: XLEN];
      end
    end
    if (w_h_rs1 == 5'd0) begin
      w_src1 = '0;
    end
    if (w_h_rs2 == 5'd0) begin
      w_src2 = '0;
    end
  end

  assign w_blocked = w_b1 | w_b2;

  assign q.in_ready  = (r_cnt != CNT_FULL) && !flush;
  assign q.out_valid = !w_empty && !w_blocked && !flush;

  assign w_push = q.in_valid && q.in_ready;
  assign w_pop  = q.out_valid && q.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage is never cleared; validity lives in r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pay[r_wptr]  <= q.in_payload;
      r_rs1[r_wptr]  <= q.in_rs1;
      r_rs2[r_wptr]  <= q.in_rs2;
      r_use2[r_wptr] <= q.in_use2;
    end
  end

`ifdef DS_PERF_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if (!w_empty && w_blocked && !flush &&
                 r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: doc/ds_issue_queue.md
DS_ISSUE_QUEUE -- requirements
Module: ds_issue_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand data width.
REQ-002 SHALL have parameter PW, default 64, opaque payload width ({inst,pc}).
REQ-003 SHALL have parameter DEPTH, default 4, queue entries, power of 2, >=2.
REQ-004 SHALL have parameter NUM_FWD, default 3, forwarding channels; index 0 = youngest producer.
REQ-005 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  discard all queued entries (branch taken/redirect).
REQ-008 SHALL have ports in_valid input 1 and in_ready output 1: fetch-side handshake.
REQ-009 SHALL have ports in_payload input PW, in_rs1 input 5, in_rs2 input 5, in_use2 input 1: entry contents.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1: execute-side handshake.
REQ-011 SHALL have ports out_payload output PW, out_src1 output XLEN, out_src2 output XLEN: issued entry and resolved operands.
REQ-012 SHALL have ports rf_raddr1 output 5, rf_raddr2 output 5, rf_rdata1 input XLEN, rf_rdata2 input XLEN: combinational register-file read.
REQ-013 SHALL have ports fwd_we input NUM_FWD, fwd_blk input NUM_FWD, fwd_waddr input 5*NUM_FWD, fwd_wdata input XLEN*NUM_FWD: per-channel producer status.
REQ-014 SHALL have port stall_cycles output 16: head-blocked cycle count.

Function
REQ-015 Queue SHALL be a circular FIFO: read/write pointers log2(DEPTH) bits wrapping naturally; count 0..DEPTH.
REQ-016 in_ready SHALL be 1 iff count<DEPTH and flush=0; no push-on-pop when full.
REQ-017 Push SHALL occur iff in_valid&&in_ready; entry visible at head no earlier than next cycle (min latency 1, no input-to-output bypass).
REQ-018 rf_raddr1/rf_raddr2 SHALL equal head rs1/rs2; out_payload SHALL equal head payload.
REQ-019 Channel i SHALL match operand k iff fwd_we[i]||fwd_blk[i], waddr_i!=0, waddr_i==rsk, and (k==1 or use2).
REQ-020 Operand value SHALL be fwd_wdata of lowest-index matching channel with fwd_we set, else rf_rdata; rs==0 SHALL yield 0.
REQ-021 Head SHALL be blocked if the lowest-index matching channel for any used operand has fwd_blk=1 (load-use).
REQ-022 out_valid SHALL be 1 iff count>0, head not blocked, flush=0.
REQ-023 Pop SHALL occur iff out_valid&&out_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-024 flush SHALL set count=0, rptr=wptr=0 next cycle, overriding any push/pop that cycle.
REQ-025 Empty queue SHALL drive out_valid=0; out_payload/operands don't-care.

Reset
REQ-026 reset SHALL take priority over flush and handshakes.
REQ-027 After reset: count=0, pointers=0, in_ready=1, out_valid=0, stall_cycles=0.
REQ-028 Reset mid-operation SHALL discard all entries; payload storage need not be cleared.

Configuration
REQ-029 Macro DS_PERF_CNT_EN SHALL compile in the stall counter.
REQ-030 With DS_PERF_CNT_EN: stall_cycles SHALL increment by 1 each cycle count>0 && head blocked && flush=0, saturating at 16'hFFFF, cleared only by reset.
REQ-031 Without DS_PERF_CNT_EN: stall_cycles SHALL be constant 0, no counter register.

Verification
REQ-032 Push 4 entries, out_ready=0 -> in_ready=0 after 4th; push 5th refused; pop order matches push order.
REQ-033 Full queue, out_ready=1 and in_valid=1 -> one pop per cycle, in_ready=1 the cycle after first pop, 8 entries drain in sequence with pointer wrap.
REQ-034 Head rs1=5, ch0 we=1 waddr=5 data=0xAAAA, ch2 we=1 waddr=5 data=0xBBBB -> out_src1=0xAAAA; rs1=0, ch0 waddr=0 -> out_src1=0.
REQ-035 Head rs2=7 use2=1, ch0 blk=1 waddr=7 for 3 cycles -> out_valid=0 for 3 cycles, stall_cycles=3 (macro on) / 0 (off); use2=0 -> no block.
REQ-036 3 entries queued, flush with in_valid=1 -> next cycle count=0, out_valid=0, pushed entry lost; new push issues 1 cycle later.
REQ-037 reset asserted with 2 entries and stall_cycles=9 -> next cycle out_valid=0, in_ready=1, stall_cycles=0.
